// File: rtl/dbg_cmd_decoder_pkg.sv
// Shared constants and state encoding for the debug-bridge command decoder.
// Consumers import dbg_dec_pkg::*.
package dbg_dec_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h10;
  localparam logic [7:0] CMD_READ    = 8'h11;
  localparam logic [7:0] WR_ACK_BYTE = 8'h10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    ADDR    = 3'd2,
    WDATA   = 3'd3,
    WR_REQ  = 3'd4,
    RD_REQ  = 3'd5,
    RD_SEND = 3'd6,
    WR_ACK  = 3'd7
  } state_t;

endpackage

// File: rtl/dbg_cmd_decoder.sv
// Debug-bridge responder: parses CMD/LEN/ADDR/DATA byte frames into 32-bit bus accesses.
// Optional macro DBG_DEC_WRITE_ACK_EN adds a one-byte status reply after each write frame.
module dbg_cmd_decoder
  import dbg_dec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_accept_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_accept_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic              run_reg;
  logic              is_wr_reg, is_wr_next;
  logic [7:0]        rem_reg, rem_next;
  logic [1:0]        lane_reg, lane_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [3:0]        wstrb_reg, wstrb_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              req_reg, req_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

  logic rx_fire, tx_fire, ack, counting, timeout_hit;

  always_comb begin
    rx_accept_o = run_reg && (state_reg == IDLE || state_reg == LEN ||
                              state_reg == ADDR || state_reg == WDATA);
  end

`ifdef DBG_DEC_WRITE_ACK_EN
  always_comb begin
    tx_valid_o = (state_reg == RD_SEND) || (state_reg == WR_ACK);
    tx_data_o  = (state_reg == WR_ACK) ? WR_ACK_BYTE : rdata_reg[{lane_reg, 3'b000} +: 8];
  end
`else
  always_comb begin
    tx_valid_o = (state_reg == RD_SEND);
    tx_data_o  = rdata_reg[{lane_reg, 3'b000} +: 8];
  end
`endif

  assign mem_req_o   = req_reg;
  assign mem_we_o    = req_reg && (state_reg == WR_REQ);
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign mem_wstrb_o = wstrb_reg;

  assign rx_fire     = rx_valid_i && rx_accept_o;
  assign tx_fire     = tx_valid_o && tx_accept_i;
  assign ack         = req_reg && mem_ack_i;
  assign counting    = (state_reg == LEN) || (state_reg == ADDR) || (state_reg == WDATA);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !rx_fire && (to_cnt_reg == TO_LAST);

  always_comb begin
    state_next  = state_reg;
    is_wr_next  = is_wr_reg;
    rem_next    = rem_reg;
    lane_next   = lane_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    wstrb_next  = wstrb_reg;
    rdata_next  = rdata_reg;
    req_next    = 1'b0;
    to_cnt_next = '0;
    if ((TIMEOUT_CYCLES != 0) && counting && !rx_fire)
      to_cnt_next = to_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: if (rx_fire && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
        is_wr_next = (rx_data_i == CMD_WRITE);
        state_next = LEN;
      end
      LEN: if (rx_fire) begin
        rem_next   = rx_data_i;
        lane_next  = 2'd0;
        state_next = ADDR;
      end
      ADDR: if (rx_fire) begin
        addr_next = {addr_reg[23:0], rx_data_i};
        lane_next = lane_reg + 2'd1;
        if (lane_reg == 2'd3) begin
          addr_next[1:0] = 2'b00;
          if (rem_reg == 8'd0) begin
`ifdef DBG_DEC_WRITE_ACK_EN
            state_next = is_wr_reg ? WR_ACK : IDLE;
`else
            state_next = IDLE;
`endif
          end else begin
            state_next = is_wr_reg ? WDATA : RD_REQ;
          end
        end
      end
      WDATA: if (rx_fire) begin
        wdata_next[{lane_reg, 3'b000} +: 8] = rx_data_i;
        wstrb_next[lane_reg] = 1'b1;
        rem_next  = rem_reg - 8'd1;
        lane_next = lane_reg + 2'd1;
        if (lane_reg == 2'd3 || rem_reg == 8'd1)
          state_next = WR_REQ;
      end
      WR_REQ: begin
        req_next = 1'b1;
        if (ack) begin
          req_next   = 1'b0;
          addr_next  = addr_reg + 32'd4;
          wdata_next = '0;
          wstrb_next = '0;
          lane_next  = 2'd0;
          if (rem_reg != 8'd0)
            state_next = WDATA;
          else begin
`ifdef DBG_DEC_WRITE_ACK_EN
            state_next = WR_ACK;
`else
            state_next = IDLE;
`endif
          end
        end
      end
      RD_REQ: begin
        req_next = 1'b1;
        if (ack) begin
          req_next   = 1'b0;
          rdata_next = mem_rdata_i;
          lane_next  = 2'd0;
          state_next = RD_SEND;
        end
      end
      RD_SEND: if (tx_fire) begin
        rem_next  = rem_reg - 8'd1;
        lane_next = lane_reg + 2'd1;
        if (rem_reg == 8'd1)
          state_next = IDLE;
        else if (lane_reg == 2'd3) begin
          addr_next  = addr_reg + 32'd4;
          state_next = RD_REQ;
        end
      end
`ifdef DBG_DEC_WRITE_ACK_EN
      WR_ACK: if (tx_fire) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase

    // A stalled frame drops any half-built word so nothing partial reaches the bus.
    if (timeout_hit) begin
      state_next = IDLE;
      wdata_next = '0;
      wstrb_next = '0;
      lane_next  = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      run_reg    <= 1'b0;
      is_wr_reg  <= 1'b0;
      rem_reg    <= '0;
      lane_reg   <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      rdata_reg  <= '0;
      req_reg    <= 1'b0;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= 1'b1;
      is_wr_reg  <= is_wr_next;
      rem_reg    <= rem_next;
      lane_reg   <= lane_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wstrb_reg  <= wstrb_next;
      rdata_reg  <= rdata_next;
      req_reg    <= req_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

endmodule
